// File: rtl/column_rasterizer_pkg.sv
// Shared raycaster definitions: screen geometry, pixel type and column FSM states.
// The frame buffer and DDA stages import this package too.
package column_rasterizer_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;

  typedef logic [15:0] rgb565_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DRAW      = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    DRAW      = ST_DRAW,
    WAIT_SWAP = ST_WAIT_SWAP
  } state_t;

endpackage

// File: rtl/column_rasterizer.sv
// Turns one wall-column descriptor into a full screen-height strip of pixel writes.
// The last column of a frame parks the block until the frame buffer swaps.
module column_rasterizer #(
  parameter int SCREEN_WIDTH  = column_rasterizer_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = column_rasterizer_pkg::SCREEN_HEIGHT,
  parameter column_rasterizer_pkg::rgb565_t CEIL_COLOR  = 16'h0000,
  parameter column_rasterizer_pkg::rgb565_t FLOOR_COLOR = 16'h4208
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [8:0]  col_index_in,
  input  logic [7:0]  col_height_in,
  input  logic [15:0] col_color_in,
  input  logic        frame_swap_in,
  output logic        ray_valid_out,
  output logic [15:0] ray_address_out,
  output logic [15:0] ray_pixel_out,
  output logic        ray_last_pixel_out
);
  import column_rasterizer_pkg::*;

  localparam logic [8:0]  LP_WIDTH    = 9'(SCREEN_WIDTH);
  localparam logic [8:0]  LP_LAST_COL = 9'(SCREEN_WIDTH - 1);
  localparam logic [15:0] LP_STRIDE   = 16'(SCREEN_WIDTH);
  localparam logic [7:0]  LP_HEIGHT   = 8'(SCREEN_HEIGHT);
  localparam logic [7:0]  LP_LAST_ROW = 8'(SCREEN_HEIGHT - 1);

  state_t      r_state;
  logic        r_ready;
  logic [8:0]  r_col;
  logic [7:0]  r_height;
  rgb565_t     r_color;
  logic        r_spanValid;
  logic [7:0]  r_top;
  logic [7:0]  r_bottom;
  logic [7:0]  r_row;
  logic [15:0] r_addr;
  logic        r_valid;
  logic        r_last;
  logic [15:0] r_address;
  rgb565_t     r_pixel;

  logic        w_accept;
  logic        w_inRange;
  logic [7:0]  w_clampH;
  logic [7:0]  w_spanTop;
  logic        w_lastRow;
  rgb565_t     w_pixel;

  assign w_accept  = col_valid_in && r_ready;
  assign w_inRange = col_index_in < LP_WIDTH;
  assign w_clampH  = (r_height > LP_HEIGHT) ? LP_HEIGHT : r_height;
  assign w_spanTop = (LP_HEIGHT - w_clampH) >> 1;
  assign w_lastRow = (r_row == LP_LAST_ROW);

  always_comb begin
    w_pixel = FLOOR_COLOR;
    if (r_row < r_top) begin
      w_pixel = CEIL_COLOR;
    end else if (r_row < r_bottom) begin
      w_pixel = r_color;
    end
  end

  // The first DRAW cycle only computes the span; pixels stream out from the second.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_col       <= '0;
      r_height    <= '0;
      r_color     <= '0;
      r_spanValid <= 1'b0;
      r_top       <= '0;
      r_bottom    <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_address   <= '0;
      r_pixel     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_inRange) begin
            r_col       <= col_index_in;
            r_height    <= col_height_in;
            r_color     <= col_color_in;
            r_spanValid <= 1'b0;
            r_state     <= DRAW;
            r_ready     <= 1'b0;
          end
        end
        DRAW: begin
          if (!r_spanValid) begin
            r_top       <= w_spanTop;
            r_bottom    <= w_spanTop + w_clampH;
            r_row       <= '0;
            r_addr      <= {7'b0, r_col};
            r_spanValid <= 1'b1;
          end else begin
            r_valid   <= 1'b1;
            r_address <= r_addr;
            r_pixel   <= w_pixel;
            r_last    <= w_lastRow && (r_col == LP_LAST_COL);
            r_row     <= r_row + 8'd1;
            r_addr    <= r_addr + LP_STRIDE;
            if (w_lastRow) begin
              if (r_col == LP_LAST_COL) begin
                r_state <= WAIT_SWAP;
              end else begin
                r_state <= IDLE;
                r_ready <= 1'b1;
              end
            end
          end
        end
        WAIT_SWAP: begin
          if (frame_swap_in) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign col_ready_out      = r_ready;
  assign ray_valid_out      = r_valid;
  assign ray_address_out    = r_address;
  assign ray_pixel_out      = r_pixel;
  assign ray_last_pixel_out = r_last;

endmodule

// File: tb/tb_column_rasterizer.sv
// Directed bench for column_rasterizer: whole-column captures compared against
// hand-derived ceiling/wall/floor splits and address sequences.
module tb_column_rasterizer;

  localparam int          W     = 320;
  localparam int          H     = 180;
  localparam logic [15:0] CEIL  = 16'h0000;
  localparam logic [15:0] FLOOR = 16'h4208;

  logic        pixelClk;
  logic        rst;
  logic        colValid;
  logic        colReady;
  logic [8:0]  colIndex;
  logic [7:0]  colHeight;
  logic [15:0] colColor;
  logic        frameSwap;
  logic        rayValid;
  logic [15:0] rayAddress;
  logic [15:0] rayPixel;
  logic        rayLast;

  int checkCount = 0;
  int errorCount = 0;

  int          capCount;
  int          capFirst;
  int          capLastK;
  int          readyHigh;
  logic [15:0] capAddr [256];
  logic [15:0] capPix  [256];
  logic        capLast [256];

  column_rasterizer #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .CEIL_COLOR   (CEIL),
    .FLOOR_COLOR  (FLOOR)
  ) dut (
    .pixel_clk_in      (pixelClk),
    .rst_in            (rst),
    .col_valid_in      (colValid),
    .col_ready_out     (colReady),
    .col_index_in      (colIndex),
    .col_height_in     (colHeight),
    .col_color_in      (colColor),
    .frame_swap_in     (frameSwap),
    .ray_valid_out     (rayValid),
    .ray_address_out   (rayAddress),
    .ray_pixel_out     (rayPixel),
    .ray_last_pixel_out(rayLast)
  );

  initial pixelClk = 1'b0;
  always #5 pixelClk = ~pixelClk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference split: rows above the span are ceiling, rows at or past its end are floor.
  function automatic logic [15:0] expColor(input int h, input logic [15:0] color, input int row);
    int hc, top, bottom;
    hc     = (h > H) ? H : h;
    top    = (H - hc) / 2;
    bottom = top + hc;
    if (row < top) return CEIL;
    if (row < bottom) return color;
    return FLOOR;
  endfunction

  task automatic applyStimulus(input int idx, input int h, input logic [15:0] color);
    @(posedge pixelClk); #1;
    colValid  = 1'b1;
    colIndex  = 9'(idx);
    colHeight = 8'(h);
    colColor  = color;
    @(posedge pixelClk); #1;
    colValid = 1'b0;
  endtask

  // Sample index k is the falling edge that follows the k-th rising edge after acceptance.
  task automatic captureColumn(input int swapAt);
    capCount  = 0;
    capFirst  = -1;
    capLastK  = -1;
    readyHigh = 0;
    for (int k = 0; k < 190; k++) begin
      @(negedge pixelClk);
      if (rayValid) begin
        if (capFirst < 0) capFirst = k;
        capLastK = k;
        if (capCount < 256) begin
          capAddr[capCount] = rayAddress;
          capPix[capCount]  = rayPixel;
          capLast[capCount] = rayLast;
        end
        capCount++;
      end
      if (k <= 180 && colReady) readyHigh++;
      frameSwap = (k == swapAt);
    end
    frameSwap = 1'b0;
  endtask

  task automatic verifyColumn(input int col, input int h, input logic [15:0] color);
    int n;
    checkOutput($sformatf("latency c%0d", col), capFirst, 2);
    checkOutput($sformatf("pixelCount c%0d", col), capCount, H);
    checkOutput($sformatf("contiguous c%0d", col), capLastK - capFirst + 1, H);
    checkOutput($sformatf("readyInDraw c%0d", col), readyHigh, 0);
    n = (capCount < H) ? capCount : H;
    for (int r = 0; r < n; r++) begin
      checkOutput($sformatf("addr c%0d r%0d", col, r), capAddr[r], col + r * W);
      checkOutput($sformatf("pixel c%0d r%0d", col, r), capPix[r], expColor(h, color, r));
      checkOutput($sformatf("last c%0d r%0d", col, r), capLast[r], (col == W - 1 && r == H - 1) ? 1 : 0);
    end
  endtask

  initial begin
    bit found;
    rst       = 1'b1;
    colValid  = 1'b0;
    colIndex  = '0;
    colHeight = '0;
    colColor  = '0;
    frameSwap = 1'b0;
    repeat (3) @(posedge pixelClk);
    #1 rst = 1'b0;
    @(negedge pixelClk);
    checkOutput("resetValid", rayValid, 0);
    checkOutput("resetLast", rayLast, 0);
    checkOutput("resetAddr", rayAddress, 0);
    checkOutput("resetPixel", rayPixel, 0);
    checkOutput("resetReady", colReady, 1);

    $display("[TB] column 5 height 60");
    applyStimulus(5, 60, 16'hF800);
    captureColumn(-1);
    verifyColumn(5, 60, 16'hF800);
    checkOutput("readyAfterC5", colReady, 1);

    $display("[TB] swap pulse while idle");
    @(negedge pixelClk);
    frameSwap = 1'b1;
    @(negedge pixelClk);
    frameSwap = 1'b0;
    checkOutput("idleSwapReady", colReady, 1);
    @(negedge pixelClk);
    checkOutput("idleSwapValid", rayValid, 0);

    $display("[TB] column 319 height 200");
    applyStimulus(319, 200, 16'h07E0);
    captureColumn(-1);
    verifyColumn(319, 200, 16'h07E0);
    @(negedge pixelClk);
    checkOutput("waitSwapReady", colReady, 0);
    checkOutput("waitSwapValid", rayValid, 0);
    colValid  = 1'b1;
    colIndex  = 9'd3;
    colHeight = 8'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge pixelClk);
      checkOutput($sformatf("waitHoldReady%0d", i), colReady, 0);
      checkOutput($sformatf("waitHoldValid%0d", i), rayValid, 0);
    end
    colValid = 1'b0;
    @(negedge pixelClk);
    checkOutput("preSwapReady", colReady, 0);
    frameSwap = 1'b1;
    @(posedge pixelClk); #1;
    frameSwap = 1'b0;
    @(negedge pixelClk);
    checkOutput("postSwapReady", colReady, 1);
    checkOutput("postSwapValid", rayValid, 0);

    $display("[TB] column 0 heights 0 and 1");
    applyStimulus(0, 0, 16'h001F);
    captureColumn(-1);
    verifyColumn(0, 0, 16'h001F);
    applyStimulus(0, 1, 16'h001F);
    captureColumn(-1);
    verifyColumn(0, 1, 16'h001F);

    $display("[TB] out-of-range column 400");
    @(posedge pixelClk); #1;
    colValid  = 1'b1;
    colIndex  = 9'd400;
    colHeight = 8'd50;
    for (int i = 0; i < 4; i++) begin
      @(negedge pixelClk);
      checkOutput($sformatf("oorReady%0d", i), colReady, 1);
      checkOutput($sformatf("oorValid%0d", i), rayValid, 0);
    end
    colValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pixelClk);
      checkOutput($sformatf("oorAfterValid%0d", i), rayValid, 0);
    end

    $display("[TB] reset at row 70 of column 10");
    applyStimulus(10, 100, 16'h7BEF);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge pixelClk);
      if (rayValid && rayAddress == 16'(10 + 70 * W)) found = 1'b1;
    end
    checkOutput("row70Found", found, 1);
    checkOutput("row70Pixel", rayPixel, 16'h7BEF);
    rst = 1'b1;
    @(negedge pixelClk);
    checkOutput("midResetValid", rayValid, 0);
    checkOutput("midResetReady", colReady, 1);
    checkOutput("midResetLast", rayLast, 0);
    rst = 1'b0;
    applyStimulus(11, 20, 16'hFFE0);
    captureColumn(-1);
    verifyColumn(11, 20, 16'hFFE0);

    $display("[TB] swap pulse during draw");
    applyStimulus(20, 90, 16'h1234);
    captureColumn(50);
    verifyColumn(20, 90, 16'h1234);
    checkOutput("readyAfterC20", colReady, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
